// File: rtl/cmd_rcv.sv
// Command-link receiver: gathers UART bytes into a buffer up to a terminator,
// presents the command to a consumer, then sends a one-byte acknowledge.
module cmd_rcv #(
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  TERM    = 8'h0D,
    parameter logic [7:0]  RESP    = 8'h0A,
    parameter int          TMO_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rx_rdy,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       cmd_rdy,
    output logic [4:0] cmd_len,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       cmd_done,
    output logic       ovf,
    output logic       tmo
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    localparam logic [2:0] ST_RCV     = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_RESP    = 3'd2;
    localparam logic [2:0] ST_WAIT_TX = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    logic [2:0]    state_q,   state_d;
    logic [4:0]    wr_ptr_q,  wr_ptr_d;
    logic [4:0]    cmd_len_q, cmd_len_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ovf_q,     ovf_d;
    logic          tmo_q,     tmo_d;

    logic [7:0]    buf_q [MAX_LEN];
    logic          buf_we;
    logic          rx_take;
    logic          is_term;

    assign is_term = (rx_data == TERM);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cmd_len_d = cmd_len_q;
        tmo_cnt_d = tmo_cnt_q;
        ovf_d     = 1'b0;
        tmo_d     = 1'b0;
        buf_we    = 1'b0;
        rx_take   = 1'b0;

        case (state_q)
            ST_RCV: begin
                rx_take = rx_rdy;
                if (rx_rdy) begin
                    tmo_cnt_d = '0;
                    if (!is_term) begin
                        if (wr_ptr_q < LEN_MAX) begin
                            buf_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 5'd1;
                        end else begin
                            ovf_d    = 1'b1;
                            wr_ptr_d = 5'd0;
                            state_d  = ST_DISCARD;
                        end
                    end else if (wr_ptr_q != 5'd0) begin
                        cmd_len_d = wr_ptr_q;
                        wr_ptr_d  = 5'd0;
                        state_d   = ST_HOLD;
                    end
                end else if (wr_ptr_q != 5'd0) begin
                    // Only a partially filled frame can go stale.
                    if (tmo_cnt_q == TMO_LAST) begin
                        tmo_d     = 1'b1;
                        tmo_cnt_d = '0;
                        wr_ptr_d  = 5'd0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
            end

            ST_DISCARD: begin
                rx_take = rx_rdy;
                if (rx_rdy) begin
                    tmo_cnt_d = '0;
                    if (is_term) begin
                        state_d = ST_RCV;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_d     = 1'b1;
                    tmo_cnt_d = '0;
                    wr_ptr_d  = 5'd0;
                    state_d   = ST_RCV;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            ST_HOLD: begin
                if (cmd_done) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_RCV;
                end
            end

            default: begin
                state_d  = ST_RCV;
                wr_ptr_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RCV;
            wr_ptr_q  <= 5'd0;
            cmd_len_q <= 5'd0;
            tmo_cnt_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmd_len_q <= cmd_len_d;
            tmo_cnt_q <= tmo_cnt_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (rst_n && buf_we) begin
            buf_q[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr < cmd_len_q) begin
            rd_data = buf_q[rd_addr[AW-1:0]];
        end
    end

    // Gating with rst_n keeps a byte pending in the UART while reset is held.
    assign clr_rx_rdy = rx_take & rst_n;
    assign cmd_rdy    = (state_q == ST_HOLD);
    assign trmt       = (state_q == ST_RESP);
    assign tx_data    = RESP;
    assign cmd_len    = cmd_len_q;
    assign ovf        = ovf_q;
    assign tmo        = tmo_q;

endmodule
